interrupt_sequencer: RTL and testbench

//  CPU-side consumer of the edge-latched NMI line (interrupt block `out`) and the level IRQ line.

---
 rtl/interrupt_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - 6502-style NMI/IRQ/BRK interrupt entry sequencer
//
// Purpose:
//   Polled at instruction boundaries, selects an interrupt source by priority
//   (NMI > IRQ > BRK) and runs the 7-cycle entry sequence: two dummy reads at
//   PC, push PCH, PCL and P on the stack page, then read the vector low/high
//   bytes and hand the target PC and updated SP back to the CPU.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   cpu_ce          CPU cycle enable; the sequencer only advances when 1
//   poll            last cycle of the current instruction
//   brk_req         current opcode is BRK (sampled with poll)
//   nmi_pending     latched NMI from the interrupt block
//   irq_n           IRQ level, active low
//   i_flag          CPU P.I, masks IRQ
//   pc_in/p_in/sp_in  CPU state captured when a source is chosen
//   din             data bus read value
//   addr/dout/rw    bus address, write data, 1=read 0=write
//   busy            sequencer owns the bus
//   nmi_clear       one-clk pulse to the interrupt block clear input
//   set_i           one-clk pulse telling the CPU to set P.I
//   sp_out/pc_out   updated SP and vector target, valid with pc_load
//   pc_load         one-clk pulse: CPU loads pc_out and sp_out
//
// Each state's bus cycle is presented on addr/dout/rw while in that state and
// is committed on the cpu_ce=1 edge that leaves it; the pulse outputs are
// registered on that edge and therefore last exactly one clk.

module interrupt_sequencer #(
  parameter logic [15:0] NMI_VECTOR = 16'hFFFA,
  parameter logic [15:0] IRQ_VECTOR = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic        poll,
  input  logic        brk_req,
  input  logic        nmi_pending,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic [15:0] pc_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        rw,
  output logic        busy,
  output logic        nmi_clear,
  output logic        set_i,
  output logic [7:0]  sp_out,
  output logic [15:0] pc_out,
  output logic        pc_load
);

  typedef enum logic [2:0] {
    IDLE,
    DUM1,
    DUM2,
    PCH,
    PCL,
    PSH,
    VLO,
    VHI
  } state_t;

  state_t      state;
  logic [15:0] pc_l;
  logic [7:0]  p_l;
  logic [7:0]  sp_l;
  logic [7:0]  lo_l;
  logic        src_nmi;
  logic        src_brk;
  logic        vec_nmi;

  logic [7:0]  sp_dec;
  logic        irq_take;
  logic        start;
  logic        take_nmi_vec;
  logic [7:0]  p_push;

  // P bits 5 and 4 are rebuilt on push (constant 1 and B), never copied.
  logic        unused_p_bits;
  assign unused_p_bits = ^p_l[5:4];

  assign sp_dec       = sp_l - 8'd1;
  assign irq_take     = !irq_n && !i_flag;
  assign start        = poll && (nmi_pending || irq_take || brk_req);
  // A late NMI seen while P is being pushed steals the vector fetch.
  assign take_nmi_vec = src_nmi || nmi_pending;
  assign p_push       = {p_l[7:6], 1'b1, src_brk, p_l[3:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc_l      <= 16'h0000;
      p_l       <= 8'h00;
      sp_l      <= 8'h00;
      lo_l      <= 8'h00;
      src_nmi   <= 1'b0;
      src_brk   <= 1'b0;
      vec_nmi   <= 1'b0;
      addr      <= 16'h0000;
      dout      <= 8'h00;
      rw        <= 1'b1;
      busy      <= 1'b0;
      nmi_clear <= 1'b0;
      set_i     <= 1'b0;
      sp_out    <= 8'h00;
      pc_out    <= 16'h0000;
      pc_load   <= 1'b0;
    end else begin
      // Pulses drop on every clk unless the enabled edge below re-raises them.
      nmi_clear <= 1'b0;
      set_i     <= 1'b0;
      pc_load   <= 1'b0;

      if (cpu_ce) begin
        case (state)
          IDLE: begin
            if (start) begin
              src_nmi <= nmi_pending;
              src_brk <= !nmi_pending && !irq_take;
              pc_l    <= pc_in;
              p_l     <= p_in;
              sp_l    <= sp_in;
              addr    <= pc_in;
              rw      <= 1'b1;
              busy    <= 1'b1;
              state   <= DUM1;
            end
          end

          DUM1: begin
            state <= DUM2;
          end

          DUM2: begin
            addr  <= {STACK_PAGE, sp_l};
            dout  <= pc_l[15:8];
            rw    <= 1'b0;
            state <= PCH;
          end

          PCH: begin
            sp_l  <= sp_dec;
            addr  <= {STACK_PAGE, sp_dec};
            dout  <= pc_l[7:0];
            state <= PCL;
          end

          PCL: begin
            sp_l  <= sp_dec;
            addr  <= {STACK_PAGE, sp_dec};
            dout  <= p_push;
            state <= PSH;
          end

          PSH: begin
            sp_l    <= sp_dec;
            vec_nmi <= take_nmi_vec;
            addr    <= take_nmi_vec ? NMI_VECTOR : IRQ_VECTOR;
            dout    <= 8'h00;
            rw      <= 1'b1;
            state   <= VLO;
          end

          VLO: begin
            lo_l      <= din;
            set_i     <= 1'b1;
            nmi_clear <= vec_nmi;
            addr      <= addr + 16'd1;
            state     <= VHI;
          end

          VHI: begin
            pc_out  <= {din, lo_l};
            sp_out  <= sp_l;
            pc_load <= 1'b1;
            busy    <= 1'b0;
            addr    <= 16'h0000;
            state   <= IDLE;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            rw    <= 1'b1;
            addr  <= 16'h0000;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - self-checking bench for interrupt_sequencer

module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ce;
  logic        poll;
  logic        brk_req;
  logic        nmi_pending;
  logic        irq_n;
  logic        i_flag;
  logic [15:0] pc_in;
  logic [7:0]  p_in;
  logic [7:0]  sp_in;
  logic [7:0]  din;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        rw;
  logic        busy;
  logic        nmi_clear;
  logic        set_i;
  logic [7:0]  sp_out;
  logic [15:0] pc_out;
  logic        pc_load;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .poll(poll), .brk_req(brk_req),
    .nmi_pending(nmi_pending), .irq_n(irq_n), .i_flag(i_flag),
    .pc_in(pc_in), .p_in(p_in), .sp_in(sp_in), .din(din),
    .addr(addr), .dout(dout), .rw(rw), .busy(busy),
    .nmi_clear(nmi_clear), .set_i(set_i), .sp_out(sp_out),
    .pc_out(pc_out), .pc_load(pc_load)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the sequence is a list of seven bus cycles derived directly
  // from the 6502 interrupt entry rules.
  task automatic run_seq(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp,
                         input bit nmi, input bit irq_low, input bit ifl, input bit brk,
                         input bit hijack, input bit slow, input int abort_at);
    int          kind;
    bit          use_nmi;
    logic [15:0] vec;
    logic [15:0] ea[7];
    logic        ew[7];
    logic [7:0]  ed[7];
    logic [7:0]  s1, s2, s3;
    logic [7:0]  lo, hi;

    kind = nmi ? 1 : (irq_low && !ifl) ? 2 : brk ? 3 : 0;

    pc_in = pc; p_in = p; sp_in = sp;
    nmi_pending = nmi; irq_n = !irq_low; i_flag = ifl; brk_req = brk;
    poll = 1'b1; cpu_ce = 1'b1;
    tick();
    poll = 1'b0; brk_req = 1'b0;

    if (kind == 0) begin
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_addr", {16'd0, addr}, 32'd0);
      nmi_pending = 1'b0;
      return;
    end

    if (kind != 1) nmi_pending = 1'b0;
    use_nmi = (kind == 1) || hijack;
    vec = use_nmi ? 16'hFFFA : 16'hFFFE;
    s1 = sp - 8'd1; s2 = sp - 8'd2; s3 = sp - 8'd3;
    ea[0] = pc;            ew[0] = 1'b1; ed[0] = 8'h00;
    ea[1] = pc;            ew[1] = 1'b1; ed[1] = 8'h00;
    ea[2] = {8'h01, sp};   ew[2] = 1'b0; ed[2] = pc[15:8];
    ea[3] = {8'h01, s1};   ew[3] = 1'b0; ed[3] = pc[7:0];
    ea[4] = {8'h01, s2};   ew[4] = 1'b0;
    ed[4] = (p & 8'hCF) | 8'h20 | ((kind == 3) ? 8'h10 : 8'h00);
    ea[5] = vec;           ew[5] = 1'b1; ed[5] = 8'h00;
    ea[6] = vec + 16'd1;   ew[6] = 1'b1; ed[6] = 8'h00;
    lo = 8'($urandom);
    hi = 8'($urandom);

    for (int k = 0; k < 7; k++) begin
      check($sformatf("addr_c%0d", k), {16'd0, addr}, {16'd0, ea[k]});
      check($sformatf("rw_c%0d", k), {31'd0, rw}, {31'd0, ew[k]});
      check($sformatf("busy_c%0d", k), {31'd0, busy}, 32'd1);
      if (!ew[k]) check($sformatf("dout_c%0d", k), {24'd0, dout}, {24'd0, ed[k]});

      if (slow) begin
        repeat (2) begin
          cpu_ce = 1'b0;
          tick();
          check($sformatf("hold_addr_c%0d", k), {16'd0, addr}, {16'd0, ea[k]});
          check($sformatf("hold_pulses_c%0d", k), {29'd0, pc_load, set_i, nmi_clear}, 32'd0);
        end
      end

      cpu_ce = 1'b1;
      if (k == 4 && hijack) nmi_pending = 1'b1;
      if (k == 5) din = lo;
      if (k == 6) din = hi;

      if (k == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nmi_pending = 1'b0;
        irq_n = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_addr", {16'd0, addr}, 32'd0);
        check("abort_rw", {31'd0, rw}, 32'd1);
        repeat (10) begin
          check("abort_no_pulse", {29'd0, pc_load, set_i, nmi_clear}, 32'd0);
          tick();
        end
        check("abort_idle", {31'd0, busy}, 32'd0);
        return;
      end

      tick();
      if (k == 5) begin
        check("set_i", {31'd0, set_i}, 32'd1);
        check("nmi_clear", {31'd0, nmi_clear}, {31'd0, use_nmi});
        check("no_pc_load_vlo", {31'd0, pc_load}, 32'd0);
      end else if (k == 6) begin
        check("pc_load", {31'd0, pc_load}, 32'd1);
        check("pc_out", {16'd0, pc_out}, {16'd0, hi, lo});
        check("sp_out", {24'd0, sp_out}, {24'd0, s3});
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_pulses", {30'd0, set_i, nmi_clear}, 32'd0);
      end else begin
        check($sformatf("pulses_c%0d", k), {29'd0, pc_load, set_i, nmi_clear}, 32'd0);
      end
    end

    cpu_ce = 1'b0;
    nmi_pending = 1'b0;
    irq_n = 1'b1;
    tick();
    check("pulse_width", {29'd0, pc_load, set_i, nmi_clear}, 32'd0);
    check("pc_out_hold", {16'd0, pc_out}, {16'd0, hi, lo});
  endtask

  initial begin
    reset = 1'b1; cpu_ce = 1'b0; poll = 1'b0; brk_req = 1'b0; nmi_pending = 1'b0;
    irq_n = 1'b1; i_flag = 1'b1; pc_in = 16'h0; p_in = 8'h0; sp_in = 8'h0; din = 8'h0;
    tick();
    tick();
    check("rst_addr", {16'd0, addr}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_rw", {31'd0, rw}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {29'd0, pc_load, set_i, nmi_clear}, 32'd0);
    check("rst_pc_out", {16'd0, pc_out}, 32'd0);
    check("rst_sp_out", {24'd0, sp_out}, 32'd0);
    reset = 1'b0;
    tick();

    // NMI with typical stack
    run_seq(16'hC123, 8'h24, 8'hFD, 1, 0, 0, 0, 0, 0, -1);
    // IRQ masked, then unmasked
    run_seq(16'h8000, 8'h04, 8'hF0, 0, 1, 1, 0, 0, 0, -1);
    run_seq(16'h8000, 8'h00, 8'hF0, 0, 1, 0, 0, 0, 0, -1);
    // BRK hijacked by NMI arriving at PSH
    run_seq(16'h1234, 8'h20, 8'hFF, 0, 0, 0, 1, 1, 0, -1);
    // BRK without hijack
    run_seq(16'h4567, 8'hC3, 8'h80, 0, 0, 1, 1, 0, 0, -1);
    // stack pointer wrap
    run_seq(16'hABCD, 8'h00, 8'h01, 0, 1, 0, 0, 0, 0, -1);
    // NMI and IRQ together: NMI wins
    run_seq(16'h2222, 8'h00, 8'h50, 1, 1, 0, 1, 0, 0, -1);
    // slow cpu_ce, then reset in PCL
    run_seq(16'h3333, 8'hFF, 8'h40, 0, 1, 0, 0, 0, 1, -1);
    run_seq(16'h5555, 8'h00, 8'h40, 0, 1, 0, 0, 0, 1, 3);
    // poll with nothing requested
    run_seq(16'h6666, 8'h00, 8'h40, 0, 0, 0, 0, 0, 0, -1);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] r;
      r = 4'($urandom);
      run_seq(16'($urandom), 8'($urandom), 8'($urandom),
              r[0], r[1], r[2], r[3], ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1);
      cpu_ce = 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
